// File: rtl/bla_subtractor16_pipe_pkg.sv
// Shared constants and the result record for the borrow-lookahead subtractor
// and the datapath blocks that consume its output.
package bla_subtractor16_pipe_pkg;

    localparam int WIDTH    = 16;
    localparam int LO_WIDTH = 8;
    localparam int GROUP_W  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow_out;
        logic             zero;
        logic             overflow;
    } sub_result_t;

endpackage

// File: rtl/bla_group4.sv
// Four-bit borrow-lookahead cell. Given per-position borrow generate/propagate
// and the borrow entering position 0, produces the borrows entering positions
// 1..3 plus the group generate/propagate for the next lookahead level.
module bla_group4
    import bla_subtractor16_pipe_pkg::*;
(
    input  logic [GROUP_W-1:0] p,
    input  logic [GROUP_W-1:0] g,
    input  logic               borrow_in,
    output logic [GROUP_W-1:1] borrow,
    output logic               grp_p,
    output logic               grp_g
);

    // Flattened lookahead equations, no ripple through the group.
    always_comb begin
        borrow[1] = g[0] | (p[0] & borrow_in);
        borrow[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & borrow_in);
        borrow[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & borrow_in);
        grp_p     = &p;
        grp_g     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule

// File: rtl/bla_subtractor16_pipe.sv
// Two-stage pipelined 16-bit subtractor: diff = a - b - borrow_in.
// Stage 1 resolves the low byte and the borrow into bit 8; stage 2 resolves
// the high byte and registers the result with borrow, zero and overflow flags.
// Valid/ready on both sides; only WIDTH=16 / LO_WIDTH=8 is supported.
module bla_subtractor16_pipe #(
    parameter int WIDTH    = bla_subtractor16_pipe_pkg::WIDTH,
    parameter int LO_WIDTH = bla_subtractor16_pipe_pkg::LO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             overflow
);

    import bla_subtractor16_pipe_pkg::*;

    localparam int HI_WIDTH = WIDTH - LO_WIDTH;

    // Signed overflow of a - b: operands differ in sign and the result sign
    // does not follow the minuend.
    function automatic logic sub_overflow(input logic a_sign, input logic b_sign,
                                          input logic diff_sign);
        return (a_sign != b_sign) && (diff_sign != a_sign);
    endfunction

    // Handshake
    logic s1_valid, s2_valid;
    logic s1_en, s2_en;

    assign s2_en    = !s2_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    // ---------------- stage 1: low byte and borrow into bit 8 ----------------
    logic [LO_WIDTH-1:0] p_lo, g_lo, d_lo, bvec_lo, diff_lo_c;
    logic [GROUP_W-1:1]  nb0_borrow, nb1_borrow, lv1_borrow;
    logic                nb0_p, nb0_g, nb1_p, nb1_g, lv1_p, lv1_g;

    assign d_lo = a[LO_WIDTH-1:0] ^ b[LO_WIDTH-1:0];
    assign p_lo = ~d_lo;
    assign g_lo = ~a[LO_WIDTH-1:0] & b[LO_WIDTH-1:0];

    bla_group4 u_nib0 (
        .p(p_lo[3:0]), .g(g_lo[3:0]), .borrow_in(borrow_in),
        .borrow(nb0_borrow), .grp_p(nb0_p), .grp_g(nb0_g)
    );

    bla_group4 u_nib1 (
        .p(p_lo[7:4]), .g(g_lo[7:4]), .borrow_in(lv1_borrow[1]),
        .borrow(nb1_borrow), .grp_p(nb1_p), .grp_g(nb1_g)
    );

    // Second lookahead level over the two low nibbles; upper slots are idle.
    bla_group4 u_lvl1 (
        .p({2'b00, nb1_p, nb0_p}), .g({2'b00, nb1_g, nb0_g}), .borrow_in(borrow_in),
        .borrow(lv1_borrow), .grp_p(lv1_p), .grp_g(lv1_g)
    );

    assign bvec_lo   = {nb1_borrow, lv1_borrow[1], nb0_borrow, borrow_in};
    assign diff_lo_c = d_lo ^ bvec_lo;

    logic [LO_WIDTH-1:0] diff_lo_p1;
    logic                borrow8_p1;
    logic [HI_WIDTH-1:0] a_hi_p1, b_hi_p1;
    logic                a_sign_p1, b_sign_p1;

    // Stage 1 data capture on accept; contents are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            diff_lo_p1 <= diff_lo_c;
            borrow8_p1 <= lv1_borrow[2];
            a_hi_p1    <= a[WIDTH-1:LO_WIDTH];
            b_hi_p1    <= b[WIDTH-1:LO_WIDTH];
            a_sign_p1  <= a[WIDTH-1];
            b_sign_p1  <= b[WIDTH-1];
        end
    end

    // ---------------- stage 2: high byte, flags, output registers ------------
    logic [HI_WIDTH-1:0] p_hi, g_hi, d_hi, bvec_hi;
    logic [GROUP_W-1:1]  nb2_borrow, nb3_borrow, lv2_borrow;
    logic                nb2_p, nb2_g, nb3_p, nb3_g, lv2_p, lv2_g;
    logic [WIDTH-1:0]    diff_c;
    sub_result_t         result_c, result_p2;

    assign d_hi = a_hi_p1 ^ b_hi_p1;
    assign p_hi = ~d_hi;
    assign g_hi = ~a_hi_p1 & b_hi_p1;

    bla_group4 u_nib2 (
        .p(p_hi[3:0]), .g(g_hi[3:0]), .borrow_in(borrow8_p1),
        .borrow(nb2_borrow), .grp_p(nb2_p), .grp_g(nb2_g)
    );

    bla_group4 u_nib3 (
        .p(p_hi[7:4]), .g(g_hi[7:4]), .borrow_in(lv2_borrow[1]),
        .borrow(nb3_borrow), .grp_p(nb3_p), .grp_g(nb3_g)
    );

    bla_group4 u_lvl2 (
        .p({2'b00, nb3_p, nb2_p}), .g({2'b00, nb3_g, nb2_g}), .borrow_in(borrow8_p1),
        .borrow(lv2_borrow), .grp_p(lv2_p), .grp_g(lv2_g)
    );

    // Idle top-level lookahead outputs (slot 3 and group terms) are not needed.
    logic unused_lookahead;
    assign unused_lookahead = ^{lv1_borrow[3], lv1_p, lv1_g, lv2_borrow[3], lv2_p, lv2_g};

    assign bvec_hi = {nb3_borrow, lv2_borrow[1], nb2_borrow, borrow8_p1};
    assign diff_c  = {d_hi ^ bvec_hi, diff_lo_p1};

    // Assemble the stage-2 result record.
    always_comb begin
        result_c.diff       = diff_c;
        result_c.borrow_out = lv2_borrow[2];
        result_c.zero       = ~|diff_c;
        result_c.overflow   = sub_overflow(a_sign_p1, b_sign_p1, diff_c[WIDTH-1]);
    end

    // Output registers hold under back-pressure and clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p2 <= '0;
        end else if (s2_en && s1_valid) begin
            result_p2 <= result_c;
        end
    end

    // Stage valids advance with their enables and clear asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_en) s1_valid <= in_valid;
            if (s2_en) s2_valid <= s1_valid;
        end
    end

    assign out_valid  = s2_valid;
    assign diff       = result_p2.diff;
    assign borrow_out = result_p2.borrow_out;
    assign zero       = result_p2.zero;
    assign overflow   = result_p2.overflow;

endmodule

// File: tb/tb_bla_subtractor16_pipe.sv
// Self-checking bench for bla_subtractor16_pipe with an arithmetic reference model.
module tb_bla_subtractor16_pipe;
    import bla_subtractor16_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        borrow_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        borrow_out, zero, overflow;

    int errors = 0;
    int checks = 0;
    sub_result_t exp_q[$];

    bla_subtractor16_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
        .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out),
        .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic sub_result_t model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mbin);
        sub_result_t r;
        int ua, ub, ud, sa, sb, sd;
        ua = int'(ma);
        ub = int'(mb);
        ud = ua - ub - int'(mbin);
        sa = $signed(ma);
        sb = $signed(mb);
        sd = sa - sb - int'(mbin);
        r.diff       = ud[15:0];
        r.borrow_out = (ud < 0);
        r.zero       = (ud[15:0] == 16'h0000);
        r.overflow   = (sd > 32767) || (sd < -32768);
        return r;
    endfunction

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic sub_result_t observed();
        return {diff, borrow_out, zero, overflow};
    endfunction

    // Drive inputs just after the falling edge, then let comb outputs settle.
    task automatic drive(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ibin, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        borrow_in = ibin;
        out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if ({diff, borrow_out, zero, overflow} !== 19'd0)
            begin errors++; $display("FAIL reset_outputs got=%h/%b%b%b want=0", diff, borrow_out, zero, overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vbin [5];
        logic [15:0] ed [5];
        sub_result_t e;
        va   = '{16'h0000, 16'h8000, 16'h7FFF, 16'h1234, 16'h0100};
        vb   = '{16'h0001, 16'h0001, 16'hFFFF, 16'h1234, 16'h00FF};
        vbin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ed   = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            e = model(va[i], vb[i], vbin[i]);
            drive(1'b1, va[i], vb[i], vbin[i], 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got=%b want=1", i, in_ready); end
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early got=%b want=0", i, out_valid); end
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency got=%b want=1", i, out_valid); end
            checks++;
            if (observed() !== e) begin errors++; $display("FAIL dir%0d_result got=%h want=%h", i, observed(), e); end
            checks++;
            if (diff !== ed[i]) begin errors++; $display("FAIL dir%0d_diff got=%h want=%h", i, diff, ed[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        sub_result_t e;
        int got = 0;
        va = '{16'h0005, 16'h0003, 16'hFFFF};
        vb = '{16'h0003, 16'h0005, 16'hFFFF};
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            drive(i < 3, va[i % 3], vb[i % 3], 1'b0, 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc%0d got=%b want=1", i, in_ready); end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, borrow_in));
            checks++;
            if (out_valid !== (i >= 2 && i <= 4))
                begin errors++; $display("FAIL b2b_out_valid cyc%0d got=%b want=%b", i, out_valid, (i >= 2 && i <= 4)); end
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got++;
                checks++;
                if (observed() !== e) begin errors++; $display("FAIL b2b_result cyc%0d got=%h want=%h", i, observed(), e); end
            end
        end
        checks++;
        if (got != 3) begin errors++; $display("FAIL b2b_count got=%0d want=3", got); end
    endtask

    task automatic test_backpressure();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        sub_result_t e, first;
        int idx = 0;
        int got = 0;
        va = '{16'h1111, 16'hA000, 16'h0000};
        vb = '{16'h0011, 16'h0001, 16'h8000};
        exp_q.delete();
        first = model(va[0], vb[0], 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(idx < 3, va[idx % 3], vb[idx % 3], 1'b0, 1'b0);
            checks++;
            if (in_ready !== (i < 2)) begin errors++; $display("FAIL bp_in_ready cyc%0d got=%b want=%b", i, in_ready, (i < 2)); end
            if (in_valid && in_ready) begin exp_q.push_back(model(a, b, borrow_in)); idx++; end
            checks++;
            if (out_valid !== (i >= 2)) begin errors++; $display("FAIL bp_out_valid cyc%0d got=%b want=%b", i, out_valid, (i >= 2)); end
            if (i >= 2) begin
                checks++;
                if (observed() !== first) begin errors++; $display("FAIL bp_hold cyc%0d got=%h want=%h", i, observed(), first); end
            end
        end
        for (int i = 0; i < 10; i++) begin
            drive(idx < 3, va[idx % 3], vb[idx % 3], 1'b0, 1'b1);
            if (in_valid && in_ready) begin exp_q.push_back(model(a, b, borrow_in)); idx++; end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra got=%h want=none", observed()); end
                else begin
                    e = exp_q.pop_front();
                    got++;
                    if (observed() !== e) begin errors++; $display("FAIL bp_result got=%h want=%h", observed(), e); end
                end
            end
        end
        checks++;
        if (got != 3 || idx != 3 || exp_q.size() != 0)
            begin errors++; $display("FAIL bp_delivery got=%0d sent=%0d left=%0d want=3/3/0", got, idx, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        drive(1'b1, 16'h4444, 16'h1111, 1'b0, 1'b0);
        drive(1'b1, 16'h2222, 16'h3333, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_prefill got=%b want=1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
        checks++;
        if ({diff, borrow_out, zero, overflow} !== 19'd0)
            begin errors++; $display("FAIL rst_mid_outputs got=%h/%b%b%b want=0", diff, borrow_out, zero, overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
        for (int i = 0; i < 6; i++) begin
            drive(i == 0, 16'h0010, 16'h0001, 1'b0, 1'b1);
            if (out_valid) begin
                got++;
                checks++;
                if (diff !== 16'h000F) begin errors++; $display("FAIL rst_mid_result got=%h want=000f", diff); end
            end
        end
        checks++;
        if (got != 1) begin errors++; $display("FAIL rst_mid_count got=%0d want=1", got); end
    endtask

    task automatic test_random();
        sub_result_t e, prev;
        logic stalled = 1'b0;
        exp_q.delete();
        prev = '0;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, pick_operand(), pick_operand(),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || observed() !== prev)
                    begin errors++; $display("FAIL rnd_hold cyc%0d got=%b/%h want=1/%h", i, out_valid, observed(), prev); end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, borrow_in));
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra cyc%0d got=%h want=none", i, observed()); end
                else begin
                    e = exp_q.pop_front();
                    if (observed() !== e) begin errors++; $display("FAIL rnd_result cyc%0d got=%h want=%h", i, observed(), e); end
                end
            end
            if (exp_q.size() > 2) begin
                checks++;
                errors++;
                $display("FAIL rnd_inflight cyc%0d got=%0d want<=2", i, exp_q.size());
            end
            stalled = out_valid && !out_ready;
            prev    = observed();
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            if (out_valid) begin
                e = exp_q.pop_front();
                checks++;
                if (observed() !== e) begin errors++; $display("FAIL rnd_drain got=%h want=%h", observed(), e); end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain_timeout left=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
